instr_fetch_unit: RTL and testbench

//  Upstream stage of the memory/immediate block. Holds the PC, issues synchronous

---
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, synchronous memory read, IR capture with valid/ready hand-off.
// Optional 1-entry prefetch buffer enabled by defining IF_PREFETCH_EN.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              Reset,
   output logic [ADDR_W-1:0] ma,
   output logic              MemRead,
   input  logic [15:0]       Mem_Out,
   output logic [15:0]       IR,
   output logic [3:0]        Opcode,
   output logic [ADDR_W-1:0] PC,
   output logic              IR_Valid,
   input  logic              IR_Ready,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] Redirect_Addr
);

   typedef enum logic [1:0] {StReq, StResp, StHold} state_e;

   localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic              mem_read;

`ifdef IF_PREFETCH_EN
   logic [15:0]       pb_q, pb_d;
   logic [ADDR_W-1:0] pb_pc_q, pb_pc_d;
   logic              pb_valid_q, pb_valid_d;
   logic              rd_pend_q, rd_pend_d;
   logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= StReq;
         fetch_pc_q <= RESET_PC;
         ir_q       <= '0;
         pc_q       <= RESET_PC;
         ir_valid_q <= 1'b0;
`ifdef IF_PREFETCH_EN
         pb_q       <= '0;
         pb_pc_q    <= RESET_PC;
         pb_valid_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_pc_q    <= RESET_PC;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         ir_q       <= ir_d;
         pc_q       <= pc_d;
         ir_valid_q <= ir_valid_d;
`ifdef IF_PREFETCH_EN
         pb_q       <= pb_d;
         pb_pc_q    <= pb_pc_d;
         pb_valid_q <= pb_valid_d;
         rd_pend_q  <= rd_pend_d;
         rd_pc_q    <= rd_pc_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      ir_d       = ir_q;
      pc_d       = pc_q;
      ir_valid_d = ir_valid_q;
      mem_read   = 1'b0;
`ifdef IF_PREFETCH_EN
      pb_d       = pb_q;
      pb_pc_d    = pb_pc_q;
      pb_valid_d = pb_valid_q;
      rd_pend_d  = 1'b0;
      rd_pc_d    = rd_pc_q;
`endif

      unique case (state_q)
         StReq: begin
            mem_read = 1'b1;
            state_d  = StResp;
         end
         StResp: begin
            ir_d       = Mem_Out;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PcInc;
            ir_valid_d = 1'b1;
            state_d    = StHold;
         end
         StHold: begin
`ifdef IF_PREFETCH_EN
            // IR slot frees up when it is empty or being consumed; refill from PB,
            // else from the read returning this cycle, else the slot goes empty.
            if (!ir_valid_q || IR_Ready) begin
               if (pb_valid_q) begin
                  ir_d       = pb_q;
                  pc_d       = pb_pc_q;
                  ir_valid_d = 1'b1;
                  pb_valid_d = 1'b0;
               end else if (rd_pend_q) begin
                  ir_d       = Mem_Out;
                  pc_d       = rd_pc_q;
                  ir_valid_d = 1'b1;
               end else begin
                  ir_valid_d = 1'b0;
               end
            end else if (rd_pend_q) begin
               pb_d       = Mem_Out;
               pb_pc_d    = rd_pc_q;
               pb_valid_d = 1'b1;
            end
            if (!pb_valid_d) begin
               mem_read   = 1'b1;
               rd_pend_d  = 1'b1;
               rd_pc_d    = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PcInc;
            end
`else
            if (IR_Ready) begin
               ir_valid_d = 1'b0;
               state_d    = StReq;
            end
`endif
         end
         default: state_d = StReq;
      endcase

      // Redirect overrides everything; any in-flight response is dropped and IR is kept.
      if (Redirect) begin
         ir_d       = ir_q;
         pc_d       = pc_q;
         fetch_pc_d = Redirect_Addr;
         ir_valid_d = 1'b0;
         state_d    = StReq;
`ifdef IF_PREFETCH_EN
         pb_valid_d = 1'b0;
         rd_pend_d  = 1'b0;
`endif
      end
   end

   assign ma       = fetch_pc_q;
   assign MemRead  = mem_read & ~Reset;
   assign IR       = ir_q;
   assign Opcode   = ir_q[15:12];
   assign PC       = pc_q;
   assign IR_Valid = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (default build): directed fetch scenarios plus a randomized
// ready/redirect run checked against a program-order model of the fetch stream.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ma;
   logic        mem_read;
   logic [15:0] mem_out = '0;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic [15:0] pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [15:0] redirect_addr;

   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .CLK          (clk),
      .Reset        (rst),
      .ma           (ma),
      .MemRead      (mem_read),
      .Mem_Out      (mem_out),
      .IR           (ir),
      .Opcode       (opcode),
      .PC           (pc),
      .IR_Valid     (ir_valid),
      .IR_Ready     (ir_ready),
      .Redirect     (redirect),
      .Redirect_Addr(redirect_addr)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory, one cycle of latency.
   always @(posedge clk) if (mem_read) mem_out <= mem[ma];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!ir_valid && n < budget) begin
         step();
         n++;
      end
      check({tag, "_valid"}, 32'(ir_valid), 32'd1);
   endtask

   task automatic expect_instr(input string tag, input logic [15:0] addr);
      logic [15:0] word;
      word = mem[addr];
      check({tag, "_ir"}, 32'(ir), 32'(word));
      check({tag, "_pc"}, 32'(pc), 32'(addr));
      check({tag, "_op"}, 32'(opcode), 32'(word[15:12]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_pc;
      int          run;
      bit          run_active;
      bit          rdy, rdr, hs;
      logic [15:0] raddr;
      int          n;

      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h06A0; mem[1] = 16'h2004; mem[2] = 16'h060A; mem[3] = 16'h1AC0;
      mem[4] = 16'h0640; mem[5] = 16'h1A04; mem[6] = 16'hA000; mem[16'hFFFF] = 16'hBEEF;

      rst = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
      step(); step();
      check("rst_valid", 32'(ir_valid), 32'd0);
      check("rst_memread", 32'(mem_read), 32'd0);
      check("rst_ma", 32'(ma), 32'h0);
      check("rst_ir", 32'(ir), 32'h0);
      check("rst_pc", 32'(pc), 32'h0);

      // 1: first fetch latency and in-order stream
      rst = 1'b0;
      #1;
      check("req_memread", 32'(mem_read), 32'd1);
      check("req_valid", 32'(ir_valid), 32'd0);
      step();
      check("resp_memread", 32'(mem_read), 32'd0);
      check("resp_valid", 32'(ir_valid), 32'd0);
      step();
      check("lat_valid", 32'(ir_valid), 32'd1);
      expect_instr("t1_0", 16'h0000);
      ir_ready = 1'b1;
      step();
      wait_valid("t1_1", 8);
      expect_instr("t1_1", 16'h0001);
      step();
      ir_ready = 1'b0;

      // 2: stall in HOLD
      wait_valid("t2", 8);
      expect_instr("t2_hold0", 16'h0002);
      for (int i = 0; i < 6; i++) begin
         step();
         check("t2_stall_valid", 32'(ir_valid), 32'd1);
         check("t2_stall_memread", 32'(mem_read), 32'd0);
         expect_instr("t2_stall", 16'h0002);
      end
      ir_ready = 1'b1;
      step();
      n = 0;
      while (!ir_valid && n < 10) begin
         step();
         n++;
      end
      check("t2_gap", 32'(n), 32'd2);
      expect_instr("t2_next", 16'h0003);

      // 3: redirect during RESP drops the in-flight word
      step();
      check("t3_req_memread", 32'(mem_read), 32'd1);
      check("t3_req_ma", 32'(ma), 32'h4);
      step();
      check("t3_resp_memread", 32'(mem_read), 32'd0);
      redirect = 1'b1; redirect_addr = 16'h0005;
      step();
      redirect = 1'b0;
      check("t3_redir_ma", 32'(ma), 32'h5);
      check("t3_redir_valid", 32'(ir_valid), 32'd0);
      wait_valid("t3_a", 8);
      expect_instr("t3_a", 16'h0005);
      step();
      wait_valid("t3_b", 8);
      expect_instr("t3_b", 16'h0006);

      // 4: redirect with handshake to 0xFFFF, then wrap
      redirect = 1'b1; redirect_addr = 16'hFFFF;
      step();
      redirect = 1'b0;
      check("t4_ma", 32'(ma), 32'hFFFF);
      wait_valid("t4_a", 8);
      expect_instr("t4_a", 16'hFFFF);
      check("t4_wrap_ma", 32'(ma), 32'h0000);
      step();
      wait_valid("t4_b", 8);
      expect_instr("t4_b", 16'h0000);

      // 5: reset mid-RESP
      step();
      step();
      check("t5_in_resp", 32'(mem_read), 32'd0);
      rst = 1'b1;
      #1;
      check("t5_valid", 32'(ir_valid), 32'd0);
      check("t5_memread", 32'(mem_read), 32'd0);
      check("t5_ma", 32'(ma), 32'h0);
      check("t5_ir", 32'(ir), 32'h0);
      step();
      check("t5_memread_held", 32'(mem_read), 32'd0);
      rst = 1'b0;
      wait_valid("t5_a", 8);
      expect_instr("t5_a", 16'h0000);

      // 6: randomized ready/redirect against a program-order model
      exp_pc = 16'h0000;
      run = 0;
      run_active = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (ir_valid) begin
            expect_instr("rnd", exp_pc);
            check("rnd_ma_hold", 32'(ma), 32'(16'(exp_pc + 16'd1)));
            check("rnd_memread_hold", 32'(mem_read), 32'd0);
            if (run_active) begin
               check("rnd_latency", 32'(run), 32'd2);
               run_active = 1'b0;
            end
         end else begin
            check("rnd_ma_fetch", 32'(ma), 32'(exp_pc));
         end
         rdy = ($urandom_range(0, 3) != 0);
         rdr = ($urandom_range(0, 19) == 0);
         raddr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                              : 16'($urandom);
         ir_ready = rdy;
         redirect = rdr;
         redirect_addr = raddr;
         hs = ir_valid && rdy;
         if (hs) exp_pc = exp_pc + 16'd1;
         if (rdr) exp_pc = raddr;
         if (hs || rdr) begin
            run = 0;
            run_active = 1'b1;
         end
         step();
         if (!ir_valid && run_active) run++;
      end
      redirect = 1'b0;
      ir_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
